// File: rtl/pack_leb128.sv
// pack_leb128 -- streaming LEB128 encoder.
//
// Takes one typed 64-bit value and emits its LEB128 encoding as bytes, one
// per cycle, under valid/ready backpressure.
//
// Parameters
//   SIGNED     1: signed varintN, 0: unsigned varuintN
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   in_valid   in_value/in_type offered
//   in_ready   encoder idle and out of reset, can take a value
//   in_value   value; only [31:0] used for i32
//   in_type    2'b00 i32, 2'b01 i64, 2'b1x illegal (float)
//   out_valid  out_byte holds an encoded byte
//   out_ready  sink accepts out_byte this cycle
//   out_byte   encoded byte, bit7 = continuation
//   out_last   final byte of the current value
//   out_len    byte count of the current value, valid with out_last
//   error      one-cycle pulse after an illegal in_type was accepted
module pack_leb128 #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [1:0]  in_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [3:0]  out_len,
    output logic        error
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t      state, state_nxt;
    logic [63:0] work;
    logic [63:0] rest;
    logic [63:0] load;
    logic [6:0]  low7;
    logic        last;
    logic [3:0]  cnt;
    logic        live_q;   // low while in reset, high from the first clock after
    logic        err_q;
    logic        accept;
    logic        legal;
    logic        fire;
    logic        fill;

    assign legal  = ~in_type[1];
    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    // Shift-in bit for the 7-bit step: sign for signed, zero for unsigned.
    assign fill = SIGNED ? work[63] : 1'b0;
    assign low7 = work[6:0];
    assign rest = {{7{fill}}, work[63:7]};

    // A signed encoding may stop once the remaining bits are pure sign
    // extension of bit 6 of the byte just emitted.
    always_comb begin
        if (SIGNED)
            last = ((rest == '0) && !low7[6]) || ((rest == '1) && low7[6]);
        else
            last = (rest == '0);
    end

    // i32 is widened so the same 64-bit shift path handles both types.
    always_comb begin
        if (in_type[0])
            load = in_value;
        else
            load = {{32{SIGNED ? in_value[31] : 1'b0}}, in_value[31:0]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && legal) state_nxt = S_EMIT;
            S_EMIT: if (fire && last)    state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            work   <= '0;
            cnt    <= '0;
            live_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            live_q <= 1'b1;
            err_q  <= accept && !legal;
            if (accept && legal) begin
                work <= load;
                cnt  <= '0;
            end else if (fire) begin
                work <= rest;
                if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end
        end
    end

    // Outputs derive from held state only, so they stay stable while the
    // sink stalls and drop to zero as soon as reset forces IDLE.
    assign in_ready  = live_q && (state == S_IDLE);
    assign out_valid = (state == S_EMIT);
    assign out_byte  = out_valid ? {~last, low7} : 8'h00;
    assign out_last  = out_valid && last;
    assign out_len   = out_last ? (cnt + 4'd1) : 4'd0;
    assign error     = err_q;

endmodule
